mcpu_core_rf_writeback: RTL and testbench

Writeback stage that produces the 4-lane register-file write interface (rd num/data, rd write-enable, predicate write-enable per lane) consumed by the core register file.
- Registers each accepted execute bundle for one cycle.
- Queues late load returns from the memory unit.
- Slots each queued load into an idle lane.
- Starvation guard stalls execute when loads cannot find a free lane.

---
 rtl/mcpu_core_pkg.sv | 20 ++
 rtl/mcpu_core_wb_loadq.sv | 45 ++++
 rtl/mcpu_core_rf_writeback.sv | 185 ++++++++++++++++++
 tb/tb_mcpu_core_rf_writeback.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcpu_core_pkg.sv
// rtl/mcpu_core_pkg.sv - shared lane/load types and widths for the writeback stage
package mcpu_core_pkg;

    localparam int NUM_LANES = 4;
    localparam int REG_NUM_W = 5;
    localparam int DATA_W    = 32;

    typedef struct packed {
        logic [REG_NUM_W-1:0] rd_num;
        logic [DATA_W-1:0]    rd_data;
        logic                 rd_we;
        logic                 pred_we;
    } wb_lane_t;

    typedef struct packed {
        logic [REG_NUM_W-1:0] rd_num;
        logic [DATA_W-1:0]    data;
    } load_ret_t;

endpackage

// File: rtl/mcpu_core_wb_loadq.sv
// rtl/mcpu_core_wb_loadq.sv - load-return FIFO with wrap-bit pointers
module mcpu_core_wb_loadq
    import mcpu_core_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push_i,
    input  load_ret_t push_data_i,
    input  logic      pop_i,
    output load_ret_t head_o,
    output logic      full_o,
    output logic      empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    load_ret_t     mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;

    // Pointer advance; the extra MSB distinguishes full from empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + PW'(1);
        end
    end

    // Entry storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/mcpu_core_rf_writeback.sv
// rtl/mcpu_core_rf_writeback.sv - 4-lane writeback with late-load slotting (optional MCPU_WB_PERF_EN counters)
module mcpu_core_rf_writeback
    import mcpu_core_pkg::*;
#(
    parameter int LOADQ_DEPTH  = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                 clkrst_core_clk,
    input  logic                 clkrst_core_rst_n,
    input  logic                 ex2wb_valid,
    output logic                 wb2ex_ready,
    input  logic [REG_NUM_W-1:0] ex2wb_rd_num0,
    input  logic [REG_NUM_W-1:0] ex2wb_rd_num1,
    input  logic [REG_NUM_W-1:0] ex2wb_rd_num2,
    input  logic [REG_NUM_W-1:0] ex2wb_rd_num3,
    input  logic [DATA_W-1:0]    ex2wb_rd_data0,
    input  logic [DATA_W-1:0]    ex2wb_rd_data1,
    input  logic [DATA_W-1:0]    ex2wb_rd_data2,
    input  logic [DATA_W-1:0]    ex2wb_rd_data3,
    input  logic                 ex2wb_rd_we0,
    input  logic                 ex2wb_rd_we1,
    input  logic                 ex2wb_rd_we2,
    input  logic                 ex2wb_rd_we3,
    input  logic                 ex2wb_pred_we0,
    input  logic                 ex2wb_pred_we1,
    input  logic                 ex2wb_pred_we2,
    input  logic                 ex2wb_pred_we3,
    input  logic                 mem2wb_valid,
    output logic                 mem2wb_ready,
    input  logic [REG_NUM_W-1:0] mem2wb_rd_num,
    input  logic [DATA_W-1:0]    mem2wb_data,
`ifdef MCPU_WB_PERF_EN
    output logic [31:0]          wb_perf_squash,
    output logic [31:0]          wb_perf_stall,
`endif
    output logic [REG_NUM_W-1:0] wb2rf_rd_num0,
    output logic [REG_NUM_W-1:0] wb2rf_rd_num1,
    output logic [REG_NUM_W-1:0] wb2rf_rd_num2,
    output logic [REG_NUM_W-1:0] wb2rf_rd_num3,
    output logic [DATA_W-1:0]    wb2rf_rd_data0,
    output logic [DATA_W-1:0]    wb2rf_rd_data1,
    output logic [DATA_W-1:0]    wb2rf_rd_data2,
    output logic [DATA_W-1:0]    wb2rf_rd_data3,
    output logic                 wb2rf_rd_we0,
    output logic                 wb2rf_rd_we1,
    output logic                 wb2rf_rd_we2,
    output logic                 wb2rf_rd_we3,
    output logic                 wb2rf_pred_we0,
    output logic                 wb2rf_pred_we1,
    output logic                 wb2rf_pred_we2,
    output logic                 wb2rf_pred_we3
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    wb_lane_t      ex_lane [NUM_LANES];
    wb_lane_t      rf_d    [NUM_LANES];
    wb_lane_t      rf_q    [NUM_LANES];
    load_ret_t     head;
    load_ret_t     push_data;
    logic          q_full;
    logic          q_empty;
    logic          q_push;
    logic          q_pop;
    logic          accept;
    logic          squash;
    logic          found;
    logic          wait_c;
    logic          hold_d;
    logic          hold_q;
    logic [SW-1:0] starve_d;
    logic [SW-1:0] starve_q;

    assign ex_lane[0] = '{rd_num: ex2wb_rd_num0, rd_data: ex2wb_rd_data0, rd_we: ex2wb_rd_we0, pred_we: ex2wb_pred_we0};
    assign ex_lane[1] = '{rd_num: ex2wb_rd_num1, rd_data: ex2wb_rd_data1, rd_we: ex2wb_rd_we1, pred_we: ex2wb_pred_we1};
    assign ex_lane[2] = '{rd_num: ex2wb_rd_num2, rd_data: ex2wb_rd_data2, rd_we: ex2wb_rd_we2, pred_we: ex2wb_pred_we2};
    assign ex_lane[3] = '{rd_num: ex2wb_rd_num3, rd_data: ex2wb_rd_data3, rd_we: ex2wb_rd_we3, pred_we: ex2wb_pred_we3};

    assign push_data = '{rd_num: mem2wb_rd_num, data: mem2wb_data};
    assign q_push    = mem2wb_valid && !q_full;
    assign q_pop     = squash || found;

    mcpu_core_wb_loadq #(
        .DEPTH (LOADQ_DEPTH)
    ) u_loadq (
        .clk         (clkrst_core_clk),
        .rst_n       (clkrst_core_rst_n),
        .push_i      (q_push),
        .push_data_i (push_data),
        .pop_i       (q_pop),
        .head_o      (head),
        .full_o      (q_full),
        .empty_o     (q_empty)
    );

    // Build the next lane set: accepted bundle, then squash or slot the queue head.
    always_comb begin
        accept = ex2wb_valid && !hold_q;
        squash = 1'b0;
        found  = 1'b0;
        for (int i = 0; i < NUM_LANES; i++) begin
            rf_d[i] = accept ? ex_lane[i] : '0;
        end
        if (!q_empty) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (rf_d[i].rd_we && (rf_d[i].rd_num == head.rd_num)) squash = 1'b1;
            end
            if (!squash) begin
                for (int i = 0; i < NUM_LANES; i++) begin
                    if (!found && !rf_d[i].rd_we) begin
                        found           = 1'b1;
                        rf_d[i].rd_num  = head.rd_num;
                        rf_d[i].rd_data = head.data;
                        rf_d[i].rd_we   = 1'b1;
                    end
                end
            end
        end
        wait_c = !q_empty && !squash && !found;
    end

    // Starvation tracking: count consecutive waits of the head, hold execute once at the limit.
    always_comb begin
        starve_d = starve_q;
        if (q_empty || q_pop) begin
            starve_d = '0;
        end else if (wait_c) begin
            starve_d = starve_q + SW'(1);
        end
        hold_d = wait_c && (starve_q == SW'(STARVE_LIMIT - 1));
    end

    // Output lanes and starvation state registers.
    always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
        if (!clkrst_core_rst_n) begin
            for (int i = 0; i < NUM_LANES; i++) rf_q[i] <= '0;
            hold_q   <= 1'b0;
            starve_q <= '0;
        end else begin
            for (int i = 0; i < NUM_LANES; i++) rf_q[i] <= rf_d[i];
            hold_q   <= hold_d;
            starve_q <= starve_d;
        end
    end

`ifdef MCPU_WB_PERF_EN
    logic [31:0] perf_squash_q;
    logic [31:0] perf_stall_q;

    // Wrapping event counters for dropped loads and held cycles.
    always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
        if (!clkrst_core_rst_n) begin
            perf_squash_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            if (squash) perf_squash_q <= perf_squash_q + 32'd1;
            if (hold_q) perf_stall_q  <= perf_stall_q + 32'd1;
        end
    end

    assign wb_perf_squash = perf_squash_q;
    assign wb_perf_stall  = perf_stall_q;
`endif

    assign wb2ex_ready  = !hold_q;
    assign mem2wb_ready = !q_full;

    assign wb2rf_rd_num0  = rf_q[0].rd_num;
    assign wb2rf_rd_num1  = rf_q[1].rd_num;
    assign wb2rf_rd_num2  = rf_q[2].rd_num;
    assign wb2rf_rd_num3  = rf_q[3].rd_num;
    assign wb2rf_rd_data0 = rf_q[0].rd_data;
    assign wb2rf_rd_data1 = rf_q[1].rd_data;
    assign wb2rf_rd_data2 = rf_q[2].rd_data;
    assign wb2rf_rd_data3 = rf_q[3].rd_data;
    assign wb2rf_rd_we0   = rf_q[0].rd_we;
    assign wb2rf_rd_we1   = rf_q[1].rd_we;
    assign wb2rf_rd_we2   = rf_q[2].rd_we;
    assign wb2rf_rd_we3   = rf_q[3].rd_we;
    assign wb2rf_pred_we0 = rf_q[0].pred_we;
    assign wb2rf_pred_we1 = rf_q[1].pred_we;
    assign wb2rf_pred_we2 = rf_q[2].pred_we;
    assign wb2rf_pred_we3 = rf_q[3].pred_we;

endmodule

// File: tb/tb_mcpu_core_rf_writeback.sv
// tb/tb_mcpu_core_rf_writeback.sv - self-checking bench for mcpu_core_rf_writeback
module tb_mcpu_core_rf_writeback;

    localparam int DEPTH = 4;
    localparam int LIMIT = 8;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        chk_en = 1'b0;
    logic        ex_valid;
    logic [4:0]  ex_num  [4];
    logic [31:0] ex_data [4];
    logic        ex_we   [4];
    logic        ex_pwe  [4];
    logic        mem_valid;
    logic [4:0]  mem_num;
    logic [31:0] mem_data;
    logic        ex_ready;
    logic        mem_ready;
    logic [4:0]  rf_num  [4];
    logic [31:0] rf_data [4];
    logic        rf_we   [4];
    logic        rf_pwe  [4];
`ifdef MCPU_WB_PERF_EN
    logic [31:0] perf_squash;
    logic [31:0] perf_stall;
`endif

    int checks = 0;
    int errors = 0;

    // Behavioural model state: queue of pending loads and expected outputs.
    logic [36:0] mq [$];
    logic        m_hold;
    int          m_wait;
    int          m_squash;
    int          m_stall;
    logic [4:0]  e_num  [4];
    logic [31:0] e_data [4];
    logic        e_we   [4];
    logic        e_pwe  [4];
    logic        e_ex_ready;
    logic        e_mem_ready;
    logic [38:0] ca;
    logic [38:0] ce;

    always #5 clk = ~clk;

    mcpu_core_rf_writeback #(
        .LOADQ_DEPTH  (DEPTH),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clkrst_core_clk   (clk),
        .clkrst_core_rst_n (rst_n),
        .ex2wb_valid       (ex_valid),
        .wb2ex_ready       (ex_ready),
        .ex2wb_rd_num0     (ex_num[0]),
        .ex2wb_rd_num1     (ex_num[1]),
        .ex2wb_rd_num2     (ex_num[2]),
        .ex2wb_rd_num3     (ex_num[3]),
        .ex2wb_rd_data0    (ex_data[0]),
        .ex2wb_rd_data1    (ex_data[1]),
        .ex2wb_rd_data2    (ex_data[2]),
        .ex2wb_rd_data3    (ex_data[3]),
        .ex2wb_rd_we0      (ex_we[0]),
        .ex2wb_rd_we1      (ex_we[1]),
        .ex2wb_rd_we2      (ex_we[2]),
        .ex2wb_rd_we3      (ex_we[3]),
        .ex2wb_pred_we0    (ex_pwe[0]),
        .ex2wb_pred_we1    (ex_pwe[1]),
        .ex2wb_pred_we2    (ex_pwe[2]),
        .ex2wb_pred_we3    (ex_pwe[3]),
        .mem2wb_valid      (mem_valid),
        .mem2wb_ready      (mem_ready),
        .mem2wb_rd_num     (mem_num),
        .mem2wb_data       (mem_data),
`ifdef MCPU_WB_PERF_EN
        .wb_perf_squash    (perf_squash),
        .wb_perf_stall     (perf_stall),
`endif
        .wb2rf_rd_num0     (rf_num[0]),
        .wb2rf_rd_num1     (rf_num[1]),
        .wb2rf_rd_num2     (rf_num[2]),
        .wb2rf_rd_num3     (rf_num[3]),
        .wb2rf_rd_data0    (rf_data[0]),
        .wb2rf_rd_data1    (rf_data[1]),
        .wb2rf_rd_data2    (rf_data[2]),
        .wb2rf_rd_data3    (rf_data[3]),
        .wb2rf_rd_we0      (rf_we[0]),
        .wb2rf_rd_we1      (rf_we[1]),
        .wb2rf_rd_we2      (rf_we[2]),
        .wb2rf_rd_we3      (rf_we[3]),
        .wb2rf_pred_we0    (rf_pwe[0]),
        .wb2rf_pred_we1    (rf_pwe[1]),
        .wb2rf_pred_we2    (rf_pwe[2]),
        .wb2rf_pred_we3    (rf_pwe[3])
    );

    // One cycle of the specification's rules, applied to the model queue.
    task automatic model_step();
        logic acc;
        logic hit;
        int   slot;
        int   sz0;
        logic waited;
        sz0    = mq.size();
        acc    = ex_valid && !m_hold;
        waited = 1'b0;
        for (int i = 0; i < 4; i++) begin
            e_num[i]  = acc ? ex_num[i]  : 5'd0;
            e_data[i] = acc ? ex_data[i] : 32'd0;
            e_we[i]   = acc ? ex_we[i]   : 1'b0;
            e_pwe[i]  = acc ? ex_pwe[i]  : 1'b0;
        end
        if (sz0 != 0) begin
            hit = 1'b0;
            for (int i = 0; i < 4; i++) if (e_we[i] && e_num[i] == mq[0][36:32]) hit = 1'b1;
            if (hit) begin
                void'(mq.pop_front());
                m_squash++;
            end else begin
                slot = -1;
                for (int i = 3; i >= 0; i--) if (!e_we[i]) slot = i;
                if (slot >= 0) begin
                    e_num[slot]  = mq[0][36:32];
                    e_data[slot] = mq[0][31:0];
                    e_we[slot]   = 1'b1;
                    void'(mq.pop_front());
                end else begin
                    waited = 1'b1;
                end
            end
        end
        if (m_hold) m_stall++;
        m_wait = waited ? m_wait + 1 : 0;
        m_hold = (m_wait == LIMIT);
        if (mem_valid && sz0 < DEPTH) mq.push_back({mem_num, mem_data});
        e_ex_ready  = !m_hold;
        e_mem_ready = (mq.size() < DEPTH);
    endtask

    // Model advances on every active edge, and clears on reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_hold = 1'b0;
            m_wait = 0;
            m_squash = 0;
            m_stall = 0;
            for (int i = 0; i < 4; i++) begin
                e_num[i] = 5'd0; e_data[i] = 32'd0; e_we[i] = 1'b0; e_pwe[i] = 1'b0;
            end
            e_ex_ready  = 1'b1;
            e_mem_ready = 1'b1;
        end else begin
            model_step();
        end
    end

    // Compare DUT outputs against the model on every falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 4; i++) begin
                ca = {rf_we[i], rf_pwe[i], (rf_we[i] | rf_pwe[i]) ? {rf_num[i], rf_data[i]} : 37'd0};
                ce = {e_we[i], e_pwe[i], (e_we[i] | e_pwe[i]) ? {e_num[i], e_data[i]} : 37'd0};
                checks++;
                if (ca !== ce) begin
                    errors++;
                    $display("FAIL model_lane%0d t=%0t act=%h exp=%h", i, $time, ca, ce);
                end
            end
            checks++;
            if ({ex_ready, mem_ready} !== {e_ex_ready, e_mem_ready}) begin
                errors++;
                $display("FAIL model_ready t=%0t act=%b%b exp=%b%b", $time, ex_ready, mem_ready, e_ex_ready, e_mem_ready);
            end
`ifdef MCPU_WB_PERF_EN
            checks++;
            if (perf_squash !== 32'(m_squash) || perf_stall !== 32'(m_stall)) begin
                errors++;
                $display("FAIL model_perf t=%0t act=%0d/%0d exp=%0d/%0d", $time, perf_squash, perf_stall, m_squash, m_stall);
            end
`endif
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic chk_we4(input string name, input logic [3:0] exp);
        chk(name, 32'({rf_we[3], rf_we[2], rf_we[1], rf_we[0]}), 32'(exp));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ex_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ex_num[i] = 5'd0; ex_data[i] = 32'd0; ex_we[i] = 1'b0; ex_pwe[i] = 1'b0;
        end
        mem_valid = 1'b0;
        mem_num   = 5'd0;
        mem_data  = 32'd0;
    endtask

    task automatic full_bundle(input logic [31:0] tag);
        ex_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ex_num[i] = 5'(i + 1); ex_data[i] = tag + 32'(i); ex_we[i] = 1'b1; ex_pwe[i] = 1'b0;
        end
    endtask

    task automatic load(input logic [4:0] n, input logic [31:0] d);
        mem_valid = 1'b1;
        mem_num   = n;
        mem_data  = d;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n  = 1'b1;
        chk_en = 1'b1;
        chk("rst_ex_ready", 32'(ex_ready), 32'd1);
        chk("rst_mem_ready", 32'(mem_ready), 32'd1);
        chk_we4("rst_we", 4'b0000);

        // Plain bundle pass-through with a predicate write on lane 2.
        ex_valid = 1'b1;
        ex_num[0] = 5'd5; ex_data[0] = 32'h11; ex_we[0] = 1'b1;
        ex_num[2] = 5'd2; ex_data[2] = 32'd1;  ex_pwe[2] = 1'b1;
        tick();
        chk_we4("pass_we", 4'b0001);
        chk("pass_num0", 32'(rf_num[0]), 32'd5);
        chk("pass_data0", rf_data[0], 32'h11);
        chk("pass_pwe2", 32'(rf_pwe[2]), 32'd1);
        idle();

        // Load slotted into the lowest idle lane.
        load(5'd7, 32'hABCD);
        tick();
        idle();
        ex_valid = 1'b1;
        ex_num[0] = 5'd3; ex_data[0] = 32'h33; ex_we[0] = 1'b1;
        ex_num[1] = 5'd4; ex_data[1] = 32'h44; ex_we[1] = 1'b1;
        tick();
        chk_we4("ins_we", 4'b0111);
        chk("ins_num2", 32'(rf_num[2]), 32'd7);
        chk("ins_data2", rf_data[2], 32'hABCD);
        idle();

        // Load squashed by a younger bundle write to the same register.
        load(5'd9, 32'h9999);
        tick();
        idle();
        ex_valid = 1'b1;
        ex_num[1] = 5'd9; ex_data[1] = 32'h22; ex_we[1] = 1'b1;
        tick();
        chk_we4("sq_we", 4'b0010);
        chk("sq_data1", rf_data[1], 32'h22);
        idle();
        tick();
        chk_we4("sq_after_we", 4'b0000);
`ifdef MCPU_WB_PERF_EN
        chk("sq_perf", perf_squash, 32'd1);
`endif

        // Starvation: LIMIT full bundles hold execute for one cycle.
        load(5'd20, 32'h5555);
        tick();
        idle();
        for (int k = 0; k < LIMIT; k++) begin
            full_bundle(32'h100 * 32'(k));
            tick();
            chk("starve_ready", 32'(ex_ready), (k < LIMIT - 1) ? 32'd1 : 32'd0);
        end
        tick();
        chk("hold_ready", 32'(ex_ready), 32'd1);
        chk_we4("hold_we", 4'b0001);
        chk("hold_num0", 32'(rf_num[0]), 32'd20);
        chk("hold_data0", rf_data[0], 32'h5555);
        tick();
        chk_we4("resume_we", 4'b1111);
        chk("resume_num0", 32'(rf_num[0]), 32'd1);
        idle();

        // Fill the queue behind full bundles, then drain across pointer wrap.
        for (int p = 0; p < DEPTH; p++) begin
            full_bundle(32'h1000 + 32'(p));
            load(5'(10 + p), 32'hA0 + 32'(p));
            tick();
        end
        chk("full_ready", 32'(mem_ready), 32'd0);
        for (int p = 0; p < 2; p++) begin
            full_bundle(32'h2000 + 32'(p));
            load(5'd14, 32'hEE);
            tick();
            chk("full_hold_ready", 32'(mem_ready), 32'd0);
        end
        idle();
        for (int p = 0; p < DEPTH; p++) begin
            tick();
            chk_we4("drain_we", 4'b0001);
            chk("drain_num0", 32'(rf_num[0]), 32'(10 + p));
            chk("drain_data0", rf_data[0], 32'hA0 + 32'(p));
        end
        tick();
        chk_we4("drain_done_we", 4'b0000);
        chk("drain_ready", 32'(mem_ready), 32'd1);

        // Reset with loads queued: they must vanish.
        for (int p = 0; p < 3; p++) begin
            full_bundle(32'h3000 + 32'(p));
            load(5'(15 + p), 32'hB0 + 32'(p));
            tick();
        end
        idle();
        rst_n = 1'b0;
        #1;
        chk_we4("mrst_we", 4'b0000);
        chk("mrst_ex_ready", 32'(ex_ready), 32'd1);
        chk("mrst_mem_ready", 32'(mem_ready), 32'd1);
        tick();
        rst_n = 1'b1;
        for (int p = 0; p < 3; p++) begin
            tick();
            chk_we4("post_rst_we", 4'b0000);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
